// File: rtl/telemetry_link_codec_if.sv
// Link bundle for the telemetry codec: rx word strobe from the deserialiser
// and the valid/ready return-word channel toward the link transmitter.
interface telemetry_link_codec_if #(
    parameter int RX_W = 24,
    parameter int TX_W = 24
);
    logic [RX_W-1:0] rx_word;
    logic            rx_valid;
    logic [TX_W-1:0] tx_word;
    logic            tx_valid;
    logic            tx_ready;

    modport master (
        input  rx_word,
        input  rx_valid,
        input  tx_ready,
        output tx_word,
        output tx_valid
    );

    modport slave (
        output rx_word,
        output rx_valid,
        output tx_ready,
        input  tx_word,
        input  tx_valid
    );
endinterface

// File: rtl/telemetry_link_codec.sv
// Telemetry link codec: registered N-field rx unpacker with staleness
// tracking, and a change/refresh-driven {state,val} tx packer.
module telemetry_link_codec #(
    parameter int NUM_FIELDS     = 3,
    parameter int FIELD_W        = 8,
    parameter int STATE_W        = 3,
    parameter int VAL_W          = 10,
    parameter int TX_W           = 24,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int REFRESH_CYCLES = 500000
) (
    input  logic                          clk,
    input  logic                          reset,
    telemetry_link_codec_if.master        link,
    output logic [NUM_FIELDS*FIELD_W-1:0] fields,
    output logic                          fields_valid,
    output logic                          stale,
    output logic [15:0]                   rx_count,
    input  logic [STATE_W-1:0]            state,
    input  logic [VAL_W-1:0]              val
);

    localparam int RX_W   = NUM_FIELDS * FIELD_W;
    localparam int CV_W   = STATE_W + VAL_W;
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int REF_W  = $clog2(REFRESH_CYCLES);

    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);
    localparam logic [REF_W-1:0]  REF_MAX  = REF_W'(REFRESH_CYCLES - 1);
    localparam logic [15:0]       CNT_MAX  = 16'hFFFF;

    typedef enum logic {
        TX_IDLE,
        TX_PEND
    } tx_state_e;

    logic [RX_W-1:0]   fields_q, fields_d;
    logic              fv_q, fv_d;
    logic              stale_q, stale_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [15:0]       cnt_q, cnt_d;

    tx_state_e         tx_state_q, tx_state_d;
    logic [TX_W-1:0]   tx_word_q, tx_word_d;
    logic [CV_W-1:0]   last_q, last_d;
    logic [REF_W-1:0]  ref_q, ref_d;
    logic              force_q, force_d;

    logic [CV_W-1:0]   cur;
    logic              slot_free;
    logic              launch;

    // Rx side: latch strobed words, track idle time and sticky staleness.
    always_comb begin
        fields_d = fields_q;
        fv_d     = 1'b0;
        stale_d  = stale_q;
        idle_d   = idle_q;
        cnt_d    = cnt_q;
        if (link.rx_valid) begin
            fields_d = link.rx_word;
            fv_d     = 1'b1;
            stale_d  = 1'b0;
            idle_d   = '0;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 16'd1;
            end
        end else begin
            if (idle_q != IDLE_MAX) begin
                idle_d = idle_q + IDLE_W'(1);
            end
            if (idle_d == IDLE_MAX) begin
                stale_d = 1'b1;
            end
        end
    end

    // Tx side: the slot frees on idle or handshake; launch on change/refresh.
    always_comb begin
        cur        = {state, val};
        tx_state_d = tx_state_q;
        tx_word_d  = tx_word_q;
        last_d     = last_q;
        ref_d      = ref_q;
        force_d    = force_q;
        slot_free  = 1'b0;

        unique case (tx_state_q)
            TX_IDLE: slot_free = 1'b1;
            TX_PEND: slot_free = link.tx_ready;
            default: slot_free = 1'b0;
        endcase

        launch = force_q || (cur != last_q) || (ref_q == REF_MAX);

        if (slot_free) begin
            if (launch) begin
                tx_state_d = TX_PEND;
                tx_word_d  = TX_W'(cur);
                last_d     = cur;
                ref_d      = '0;
                force_d    = 1'b0;
            end else begin
                tx_state_d = TX_IDLE;
                if (ref_q != REF_MAX) begin
                    ref_d = ref_q + REF_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fields_q   <= '0;
            fv_q       <= 1'b0;
            stale_q    <= 1'b1;
            idle_q     <= '0;
            cnt_q      <= '0;
            tx_state_q <= TX_IDLE;
            tx_word_q  <= '0;
            last_q     <= '0;
            ref_q      <= '0;
            force_q    <= 1'b1;
        end else begin
            fields_q   <= fields_d;
            fv_q       <= fv_d;
            stale_q    <= stale_d;
            idle_q     <= idle_d;
            cnt_q      <= cnt_d;
            tx_state_q <= tx_state_d;
            tx_word_q  <= tx_word_d;
            last_q     <= last_d;
            ref_q      <= ref_d;
            force_q    <= force_d;
        end
    end

    assign fields        = fields_q;
    assign fields_valid  = fv_q;
    assign stale         = stale_q;
    assign rx_count      = cnt_q;
    assign link.tx_word  = tx_word_q;
    assign link.tx_valid = (tx_state_q == TX_PEND);

endmodule
